imem_arbiter: RTL

Arbiter and sequencer for the byte-wide, word-read instruction memory. It shares the single memory port between the fetch stage (32-bit reads) and the program loader (32-bit word writes). Each loader word is serialized into four byte writes. The block also holds the core in a boot phase until the loader signals completion. It sits between the fetch stage / boot loader and the instruction memory array.

---
 rtl/imem_pkg.sv | 20 ++
 rtl/imem_byte_serializer.sv | 55 +++++
 rtl/imem_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
//   state_t        : arbiter states (BOOT, RUN, WR)
//   BYTES_PER_WORD : byte lanes per 32-bit memory word
//   byte_lane()    : selects one byte lane of a 32-bit word
package imem_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WR   = 2'd2
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Byte lane `lane` of `word`; lane 0 is the least significant byte.
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/imem_byte_serializer.sv
// Serializes one 32-bit loader word into four sequential byte writes, LSB first.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : capture word/base and begin the sequence (ignored while busy)
//   base       : word-aligned byte address of lane 0
//   word       : word to write
//   byte_we    : a byte write is being issued this cycle
//   byte_addr  : address of the current byte (base + k, wraps)
//   byte_data  : data of the current byte
//   done       : current byte is the last of the word (k = 3)
module imem_byte_serializer #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [31:0]           word,
  output logic                  byte_we,
  output logic [ADDR_WIDTH-1:0] byte_addr,
  output logic [7:0]            byte_data,
  output logic                  done
);
  import imem_pkg::*;

  logic                  busy;
  logic [1:0]            k;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           word_q;

  // Capture on start, then step the byte counter once per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      k      <= 2'd0;
      base_q <= '0;
      word_q <= '0;
    end else if (start && !busy) begin
      busy   <= 1'b1;
      k      <= 2'd0;
      base_q <= base;
      word_q <= word;
    end else if (busy) begin
      k <= k + 2'd1;
      if (k == 2'(BYTES_PER_WORD - 1)) busy <= 1'b0;
    end
  end

  // Address arithmetic wraps naturally at ADDR_WIDTH bits.
  assign byte_we   = busy;
  assign byte_addr = busy ? base_q + ADDR_WIDTH'(k) : '0;
  assign byte_data = busy ? byte_lane(word_q, k) : 8'h00;
  assign done      = busy && (k == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_arbiter.sv
// Shares the byte-write / word-read instruction memory port between the fetch
// stage and the program loader, and holds the core in BOOT until load completes.
// Optional feature macro: IMEM_RUNTIME_WRITE_EN (loader writes allowed in RUN,
// subject to a fetch-starvation limit). Undefined: loader is blocked in RUN.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   if_req/if_addr/if_gnt           : fetch request, address, same-cycle grant
//   if_valid/if_rdata               : fetched word, one cycle after grant
//   ld_wr_valid/ld_addr/ld_wdata    : loader word write request
//   ld_wr_ready                     : loader word accepted (with ld_wr_valid)
//   ld_done                         : pulse, program load complete
//   boot_active                     : high until RUN is entered
//   mem_en/mem_we/mem_addr/mem_wdata: memory port strobe, write enable, address, byte
//   mem_rdata                       : memory read word, one cycle after a read strobe
module imem_arbiter #(
  parameter int unsigned INST_MEMORY_SIZE = 1024,
  parameter int unsigned ADDR_WIDTH       = $clog2(INST_MEMORY_SIZE),
  parameter int unsigned STARVE_LIMIT     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_valid,
  output logic [31:0]           if_rdata,
  input  logic                  ld_wr_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [31:0]           ld_wdata,
  output logic                  ld_wr_ready,
  input  logic                  ld_done,
  output logic                  boot_active,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [31:0]           mem_rdata
);
  import imem_pkg::*;

  state_t                state;
  logic                  from_run;
  logic                  done_pend;
  logic                  accept;
  logic                  loader_win;
  logic                  ser_we;
  logic                  ser_done;
  logic [ADDR_WIDTH-1:0] ser_addr;
  logic [7:0]            ser_data;
  logic [ADDR_WIDTH-1:0] ld_base;

`ifdef IMEM_RUNTIME_WRITE_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  // Loader wins when fetch is idle or fetch has already starved it long enough.
  assign loader_win = ld_wr_valid && (!if_req || (starve_cnt == CNT_W'(STARVE_LIMIT)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (accept) begin
      starve_cnt <= '0;
    end else if ((state == RUN) && ld_wr_valid && if_req && !ld_wr_ready &&
                 (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  logic [31:0] unused_starve_limit;
  assign unused_starve_limit = 32'(STARVE_LIMIT);
  assign loader_win          = 1'b0;
`endif

  // Grant and ready are decided combinationally from state and requests.
  always_comb begin
    if_gnt      = 1'b0;
    ld_wr_ready = 1'b0;
    case (state)
      BOOT: ld_wr_ready = 1'b1;
      RUN: begin
        if_gnt      = if_req && !loader_win;
        ld_wr_ready = loader_win;
      end
      default: ;
    endcase
  end

  assign accept  = ld_wr_valid && ld_wr_ready;
  assign ld_base = ld_addr & ~ADDR_WIDTH'(3);

  imem_byte_serializer #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept),
    .base     (ld_base),
    .word     (ld_wdata),
    .byte_we  (ser_we),
    .byte_addr(ser_addr),
    .byte_data(ser_data),
    .done     (ser_done)
  );

  // Memory port: serializer owns it during WR, otherwise a granted fetch.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    if (ser_we) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ser_addr;
      mem_wdata = ser_data;
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end
  end

  assign if_rdata = if_valid ? mem_rdata : 32'h0;

  // Arbiter FSM; a word accepted together with ld_done defers the exit until WR ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BOOT;
      boot_active <= 1'b1;
      if_valid    <= 1'b0;
      from_run    <= 1'b0;
      done_pend   <= 1'b0;
    end else begin
      if_valid <= if_gnt;
      case (state)
        BOOT: begin
          if (accept) begin
            state     <= WR;
            from_run  <= 1'b0;
            done_pend <= ld_done;
          end else if (ld_done) begin
            state       <= RUN;
            boot_active <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            state     <= WR;
            from_run  <= 1'b1;
            done_pend <= 1'b0;
          end
        end
        WR: begin
          if (ld_done) done_pend <= 1'b1;
          if (ser_done) begin
            done_pend <= 1'b0;
            if (from_run || done_pend || ld_done) begin
              state       <= RUN;
              boot_active <= 1'b0;
            end else begin
              state <= BOOT;
            end
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
